// File: rtl/pixel_write_buffer_pkg.sv
// Shared definitions for the pixel write buffer: screen defaults, frame FSM encoding,
// queued pixel layout and RGB333 packing helper.
package pixel_write_buffer_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } frame_state_e;

    // One FIFO entry: 8 + 7 + 24 = 39 bits.
    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [23:0] colour;
    } pixel_t;

    function automatic logic [8:0] pack_rgb333(input logic [2:0] r,
                                               input logic [2:0] g,
                                               input logic [2:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/pixel_write_buffer_fifo.sv
// Synchronous pixel FIFO: DEPTH entries of W bits, show-ahead read data,
// occupancy count one bit wider than the pointers so "full" is unambiguous.
module pixel_write_buffer_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Buffers clipped pixel writes, reduces RGB888 to RGB333 and plots them into the VGA adapter.
// Define PIXEL_DITHER_EN for 2x2 ordered dither (adds one pipeline stage).
module pixel_write_buffer
    import pixel_write_buffer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  inX,
    input  logic [7:0]  inY,
    input  logic [23:0] inColour,
    input  logic        inValid,
    output logic        inReady,
    input  logic        frameEnd,
    input  logic        vgaBusy,
    output logic [7:0]  vgaX,
    output logic [6:0]  vgaY,
    output logic [8:0]  vgaColour,
    output logic        vgaPlot,
    output logic        frameDone,
    output logic        overflow,
    output logic [1:0]  dbg_state
);

    // Handshake: a pixel transfers on a cycle where inValid && inReady; inReady depends
    // only on FIFO occupancy, never on inValid. vgaBusy gates the pop, not the plot strobe.

    localparam int CW = $clog2(DEPTH) + 1;

    frame_state_e  state_q, state_d;
    pixel_t        fifo_wdata, fifo_rdata, load_pix;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          in_fire, in_clip, push, pop, load, pending;
    logic [7:0]    vga_x_q, vga_x_d;
    logic [6:0]    vga_y_q, vga_y_d;
    logic [8:0]    vga_colour_q, vga_colour_d;
    logic          plot_q, plot_d;
    logic          overflow_q, overflow_d;

    assign inReady    = (fifo_count != CW'(DEPTH));
    assign in_fire    = inValid && inReady;
    assign in_clip    = (int'(inX) >= SCREEN_W) || (int'(inY) >= SCREEN_H);
    assign push       = in_fire && !in_clip;
    assign pop        = !fifo_empty && !vgaBusy;
    assign fifo_wdata = '{x: inX, y: inY[6:0], colour: inColour};

    pixel_write_buffer_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(pixel_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef PIXEL_DITHER_EN
    pixel_t stage_q, stage_d;
    logic   stage_vld_q, stage_vld_d;

    function automatic logic [4:0] dither_thr(input logic x0, input logic y0);
        case ({y0, x0})
            2'b00:   return 5'd0;
            2'b01:   return 5'd16;
            2'b10:   return 5'd24;
            default: return 5'd8;
        endcase
    endfunction

    // Saturating add, then keep the top three bits.
    function automatic logic [2:0] dither_chan(input logic [7:0] c8, input logic [4:0] t);
        logic [8:0] sum;
        sum = {1'b0, c8} + {4'b0, t};
        return sum[8] ? 3'b111 : sum[7:5];
    endfunction

    function automatic logic [8:0] reduce_colour(input pixel_t p);
        logic [4:0] t;
        t = dither_thr(p.x[0], p.y[0]);
        return pack_rgb333(dither_chan(p.colour[23:16], t),
                           dither_chan(p.colour[15:8], t),
                           dither_chan(p.colour[7:0], t));
    endfunction

    always_comb begin
        stage_d     = pop ? fifo_rdata : stage_q;
        stage_vld_d = pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
        end
    end

    assign load     = stage_vld_q;
    assign load_pix = stage_q;
    assign pending  = pop || stage_vld_q;
`else
    function automatic logic [8:0] reduce_colour(input pixel_t p);
        return pack_rgb333(p.colour[23:21], p.colour[15:13], p.colour[7:5]);
    endfunction

    assign load     = pop;
    assign load_pix = fifo_rdata;
    assign pending  = pop;
`endif

    always_comb begin
        vga_x_d      = load ? load_pix.x : vga_x_q;
        vga_y_d      = load ? load_pix.y : vga_y_q;
        vga_colour_d = load ? reduce_colour(load_pix) : vga_colour_q;
        plot_d       = load;
        overflow_d   = overflow_q || (inValid && fifo_full && (state_q == ST_FILL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            overflow_q   <= overflow_d;
        end
    end

    // A pixel accepted together with frameEnd in IDLE makes a one-pixel frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire && frameEnd) state_d = ST_DRAIN;
                else if (in_fire)        state_d = ST_FILL;
                else if (frameEnd)       state_d = ST_DONE;
            end
            ST_FILL: begin
                if (frameEnd) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && !pending && !push) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = in_fire ? ST_FILL : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Strobes are masked during reset so nothing is plotted or reported in that cycle.
    assign vgaX      = vga_x_q;
    assign vgaY      = vga_y_q;
    assign vgaColour = vga_colour_q;
    assign vgaPlot   = plot_q && !reset;
    assign frameDone = (state_q == ST_DONE) && !reset;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench for pixel_write_buffer: scoreboard of expected plots plus directed frame scenarios.
// Build with PIXEL_DITHER_EN defined to exercise the dither colour path and latency.
module tb_pixel_write_buffer;

`ifdef PIXEL_DITHER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  inX = '0;
  logic [7:0]  inY = '0;
  logic [23:0] inColour = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        frameEnd = 1'b0;
  logic        vgaBusy;
  logic [7:0]  vgaX;
  logic [6:0]  vgaY;
  logic [8:0]  vgaColour;
  logic        vgaPlot;
  logic        frameDone;
  logic        overflow;
  logic [1:0]  dbg_state;

  logic        busy_hold = 1'b0;
  logic        busy_toggle = 1'b0;
  logic        busy_phase_bit = 1'b0;
  int          busy_ph = 0;

  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          plot_count = 0;
  int          done_count = 0;
  int          base_plots, base_done;

  assign vgaBusy = busy_toggle ? busy_phase_bit : busy_hold;

  pixel_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .inX       (inX),
    .inY       (inY),
    .inColour  (inColour),
    .inValid   (inValid),
    .inReady   (inReady),
    .frameEnd  (frameEnd),
    .vgaBusy   (vgaBusy),
    .vgaX      (vgaX),
    .vgaY      (vgaY),
    .vgaColour (vgaColour),
    .vgaPlot   (vgaPlot),
    .frameDone (frameDone),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // vgaBusy high one cycle in three while toggling is enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      busy_ph = (busy_ph == 2) ? 0 : busy_ph + 1;
      busy_phase_bit = (busy_ph == 0);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model_colour(input logic [23:0] c, input logic [7:0] x,
                                              input logic [7:0] y);
`ifdef PIXEL_DITHER_EN
    int t, r, g, b;
    logic [7:0] r8, g8, b8;
    if (!y[0] && !x[0]) t = 0;
    else if (!y[0] && x[0]) t = 16;
    else if (y[0] && !x[0]) t = 24;
    else t = 8;
    r = int'(c[23:16]) + t; if (r > 255) r = 255;
    g = int'(c[15:8]) + t;  if (g > 255) g = 255;
    b = int'(c[7:0]) + t;   if (b > 255) b = 255;
    r8 = r[7:0]; g8 = g[7:0]; b8 = b[7:0];
    return {r8[7:5], g8[7:5], b8[7:5]};
`else
    return {c[23:21], c[15:13], c[7:5]};
`endif
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (vgaPlot) begin
        plot_count++;
        if (exp_q.size() == 0) begin
          check("plot_unexpected", 64'(vgaPlot), 64'd0);
        end else begin
          check("plot_pixel", 64'({vgaX, vgaY, vgaColour}), 64'(exp_q.pop_front()));
        end
      end
      if (frameDone) done_count++;
    end
  end

  // driver: present a pixel, wait for inReady, transfer on the next edge
  task automatic send_px(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c,
                         input logic fe, input logic [8:0] exp_col);
    int waited = 0;
    inX = x; inY = y; inColour = c; inValid = 1'b1; frameEnd = 1'b0;
    while (!inReady && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!inReady) begin
      check("send_timeout", 64'(inReady), 64'd1);
      inValid = 1'b0;
      return;
    end
    frameEnd = fe;
    if (x < 8'd160 && y < 8'd120) exp_q.push_back({x, y[6:0], exp_col});
    @(posedge clk);
    #1;
    inValid = 1'b0;
    frameEnd = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c,
                            input logic fe);
    send_px(x, y, c, fe, model_colour(c, x, y));
  endtask

  task automatic pulse_frame_end();
    frameEnd = 1'b1;
    @(posedge clk);
    #1;
    frameEnd = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_count < target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [7:0] last_x, last_y;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_inReady", 64'(inReady), 64'd1);
    check("rst_vgaPlot", 64'(vgaPlot), 64'd0);
    check("rst_vgaX", 64'(vgaX), 64'd0);
    check("rst_vgaY", 64'(vgaY), 64'd0);
    check("rst_vgaColour", 64'(vgaColour), 64'd0);
    check("rst_frameDone", 64'(frameDone), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // single pixel with frameEnd in the same cycle
    base_plots = plot_count; base_done = done_count;
    send_px(8'd10, 8'd20, 24'hFF8040, 1'b1, 9'b111_100_010);
    lat = 1;
    @(negedge clk);
    while (!vgaPlot && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", 64'(lat), 64'(LAT));
    check("t1_pixel", 64'({vgaX, vgaY, vgaColour}), 64'({8'd10, 7'd20, 9'b111_100_010}));
    @(negedge clk);
    check("t1_frameDone", 64'(frameDone), 64'd1);
    check("t1_plot_once", 64'(vgaPlot), 64'd0);
    idle(5);
    check("t1_plots", 64'(plot_count - base_plots), 64'd1);
    check("t1_dones", 64'(done_count - base_done), 64'd1);

    // fill to capacity under backpressure, then overflow, then drain in order
    base_plots = plot_count; base_done = done_count;
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) send_pixel(8'(i * 7), 8'd30, 24'($urandom), 1'b0);
    check("t2_inReady_full", 64'(inReady), 64'd0);
    check("t2_no_overflow_yet", 64'(overflow), 64'd0);
    inX = 8'd99; inY = 8'd31; inColour = 24'h123456; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_still_full", 64'(inReady), 64'd0);
    pulse_frame_end();
    busy_hold = 1'b0;
    wait_done(base_done + 1, 200);
    idle(3);
    check("t2_plots", 64'(plot_count - base_plots), 64'd16);
    check("t2_dones", 64'(done_count - base_done), 64'd1);
    check("t2_overflow_sticky", 64'(overflow), 64'd1);

    // clipped pixels only
    base_plots = plot_count; base_done = done_count;
    send_pixel(8'd160, 8'd5, 24'hFFFFFF, 1'b0);
    send_pixel(8'd3, 8'd120, 24'hFFFFFF, 1'b0);
    send_pixel(8'd255, 8'd255, 24'hFFFFFF, 1'b0);
    pulse_frame_end();
    wait_done(base_done + 1, 50);
    idle(3);
    check("t3_plots", 64'(plot_count - base_plots), 64'd0);
    check("t3_dones", 64'(done_count - base_done), 64'd1);

    // reset with pixels queued
    busy_hold = 1'b1;
    for (int i = 0; i < 8; i++) send_pixel(8'(i), 8'(i), 24'($urandom), 1'b0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t4_plot_in_reset", 64'(vgaPlot), 64'd0);
    check("t4_done_in_reset", 64'(frameDone), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    busy_hold = 1'b0;
    base_plots = plot_count; base_done = done_count;
    @(negedge clk);
    check("t4_inReady", 64'(inReady), 64'd1);
    check("t4_vgaPlot", 64'(vgaPlot), 64'd0);
    check("t4_overflow_clr", 64'(overflow), 64'd0);
    check("t4_state", 64'(dbg_state), 64'd0);
    idle(30);
    check("t4_plots", 64'(plot_count - base_plots), 64'd0);
    check("t4_dones", 64'(done_count - base_done), 64'd0);

`ifdef PIXEL_DITHER_EN
    // dither thresholds
    base_plots = plot_count; base_done = done_count;
    send_px(8'd1, 8'd1, 24'h303030, 1'b0, 9'b001_001_001);
    send_px(8'd0, 8'd0, 24'h303030, 1'b0, 9'b001_001_001);
    send_px(8'd0, 8'd1, 24'h303030, 1'b0, 9'b010_010_010);
    send_px(8'd1, 8'd0, 24'hF0F0F0, 1'b1, 9'b111_111_111);
    wait_done(base_done + 1, 100);
    check("t6_plots", 64'(plot_count - base_plots), 64'd4);
`endif

    // full raster scan with periodic backpressure
    base_plots = plot_count; base_done = done_count;
    busy_toggle = 1'b1;
    last_x = 8'd159; last_y = 8'd119;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        send_pixel(8'(x), 8'(y), 24'($urandom),
                   (8'(x) == last_x) && (8'(y) == last_y));
      end
    end
    wait_done(base_done + 1, 500);
    busy_toggle = 1'b0;
    idle(5);
    check("t5_plots", 64'(plot_count - base_plots), 64'd19200);
    check("t5_dones", 64'(done_count - base_done), 64'd1);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t5_idle", 64'(dbg_state), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
